// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb sequencer with PC, retire count and stage timeout
module exec_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt_req,
    output logic        fetch_go,
    input  logic        fetch_done,
    output logic        decode_go,
    input  logic        decode_done,
    input  logic        mem_needed,
    output logic        exec_go,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        mem_go,
    input  logic        mem_ready,
    output logic        wb_go,
    output logic [31:0] pc,
    output logic        busy,
    output logic [2:0]  state,
    output logic [31:0] instr_count,
    output logic        timeout_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    logic [2:0]  state_q;
    logic [7:0]  wait_cnt;
    logic        mem_flag;
    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic [31:0] count_q;
    logic        err_q;

    logic        in_wait;
    logic        first_cycle;
    logic        stage_done;
    logic        accept;
    logic        expire;

    // The wait counter is zero only in the entry cycle of a wait state, so it doubles as the go flag.
    assign in_wait     = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                         (state_q == S_EXEC)  || (state_q == S_MEM);
    assign first_cycle = in_wait && (wait_cnt == 8'd0);

    always_comb begin
        stage_done = 1'b0;
        case (state_q)
            S_FETCH:  stage_done = fetch_done;
            S_DECODE: stage_done = decode_done;
            S_EXEC:   stage_done = exec_done;
            S_MEM:    stage_done = mem_ready;
            default:  stage_done = 1'b0;
        endcase
    end

    assign accept = in_wait && !first_cycle && stage_done;
    assign expire = in_wait && !accept && (wait_cnt >= TMO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wait_cnt <= 8'd0;
            mem_flag <= 1'b0;
            pc_q     <= RESET_PC;
            next_pc  <= RESET_PC;
            count_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    wait_cnt <= 8'd0;
                    if (start) begin
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH, S_DECODE, S_EXEC, S_MEM: begin
                    if (accept) begin
                        wait_cnt <= 8'd0;
                        case (state_q)
                            S_FETCH: state_q <= S_DECODE;
                            S_DECODE: begin
                                mem_flag <= mem_needed;
                                state_q  <= S_EXEC;
                            end
                            S_EXEC: begin
                                next_pc <= branch_taken ? branch_target : pc_q + 32'd4;
                                state_q <= mem_flag ? S_MEM : S_WB;
                            end
                            default: state_q <= S_WB;
                        endcase
                    end else if (expire) begin
                        // Abandon the instruction: pc and instr_count stay as they were.
                        wait_cnt <= 8'd0;
                        err_q    <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_WB: begin
                    wait_cnt <= 8'd0;
                    pc_q     <= next_pc;
                    count_q  <= count_q + 32'd1;
                    state_q  <= halt_req ? S_HALT : S_FETCH;
                end
                S_HALT: begin
                    wait_cnt <= 8'd0;
                    if (start && !halt_req) begin
                        state_q <= S_FETCH;
                    end
                end
                default: begin
                    wait_cnt <= 8'd0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign fetch_go    = first_cycle && (state_q == S_FETCH);
    assign decode_go   = first_cycle && (state_q == S_DECODE);
    assign exec_go     = first_cycle && (state_q == S_EXEC);
    assign mem_go      = first_cycle && (state_q == S_MEM);
    assign wb_go       = (state_q == S_WB);
    assign busy        = in_wait || (state_q == S_WB);
    assign state       = state_q;
    assign pc          = pc_q;
    assign instr_count = count_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - directed self-checking bench for exec_sequencer
module tb_exec_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, halt_req;
    logic        fetch_done, decode_done, mem_needed, exec_done, branch_taken, mem_ready;
    logic [31:0] branch_target;

    logic        fetch_go, decode_go, exec_go, mem_go, wb_go, busy, timeout_err;
    logic [31:0] pc, instr_count;
    logic [2:0]  state;

    logic        t_fetch_go, t_decode_go, t_exec_go, t_mem_go, t_wb_go, t_busy, t_timeout_err;
    logic [31:0] t_pc, t_instr_count;
    logic [2:0]  t_state;

    logic        sel;
    logic        m_fetch_go, m_decode_go, m_exec_go, m_mem_go, m_wb_go, m_busy, m_err;
    logic [31:0] m_pc, m_count;
    logic [2:0]  m_state;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_fetch = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    exec_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .fetch_go(fetch_go), .fetch_done(fetch_done),
        .decode_go(decode_go), .decode_done(decode_done), .mem_needed(mem_needed),
        .exec_go(exec_go), .exec_done(exec_done),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .mem_go(mem_go), .mem_ready(mem_ready), .wb_go(wb_go),
        .pc(pc), .busy(busy), .state(state), .instr_count(instr_count),
        .timeout_err(timeout_err)
    );

    exec_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut_t (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .fetch_go(t_fetch_go), .fetch_done(fetch_done),
        .decode_go(t_decode_go), .decode_done(decode_done), .mem_needed(mem_needed),
        .exec_go(t_exec_go), .exec_done(exec_done),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .mem_go(t_mem_go), .mem_ready(mem_ready), .wb_go(t_wb_go),
        .pc(t_pc), .busy(t_busy), .state(t_state), .instr_count(t_instr_count),
        .timeout_err(t_timeout_err)
    );

    assign m_fetch_go  = sel ? t_fetch_go    : fetch_go;
    assign m_decode_go = sel ? t_decode_go   : decode_go;
    assign m_exec_go   = sel ? t_exec_go     : exec_go;
    assign m_mem_go    = sel ? t_mem_go      : mem_go;
    assign m_wb_go     = sel ? t_wb_go       : wb_go;
    assign m_busy      = sel ? t_busy        : busy;
    assign m_err       = sel ? t_timeout_err : timeout_err;
    assign m_pc        = sel ? t_pc          : pc;
    assign m_count     = sel ? t_instr_count : instr_count;
    assign m_state     = sel ? t_state       : state;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic go_of(input int which);
        case (which)
            0: return m_fetch_go;
            1: return m_decode_go;
            2: return m_exec_go;
            default: return m_mem_go;
        endcase
    endfunction

    task automatic wait_go(input int which);
        for (int i = 0; i < 400; i++) begin
            if (go_of(which)) break;
            step();
        end
        check($sformatf("go_seen_%0d", which), {31'd0, go_of(which)}, 32'd1);
    endtask

    task automatic set_done(input int which, input logic v);
        case (which)
            0: fetch_done = v;
            1: decode_done = v;
            2: exec_done = v;
            default: mem_ready = v;
        endcase
    endtask

    task automatic do_stage(input int which, input int d);
        wait_go(which);
        repeat (d) step();
        set_done(which, 1'b1);
        step();
        set_done(which, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // One full instruction; stages answer one cycle after go except exec (ed) and mem (md).
    task automatic run_instr(input logic [31:0] exp_pc, input logic [31:0] exp_next,
                             input logic [31:0] exp_cnt, input logic mem, input int md,
                             input logic taken, input logic [31:0] target, input int ed,
                             input logic do_halt, input logic pulse, input int exp_per);
        int mcyc;
        int mgo;
        mem_needed    = mem;
        branch_taken  = taken;
        branch_target = target;
        wait_go(0);
        check("pc_at_fetch", m_pc, exp_pc);
        if (exp_per != 0) check("instr_period", 32'(cyc - last_fetch), 32'(exp_per));
        last_fetch = cyc;
        if (pulse) halt_req = 1'b1;
        do_stage(0, 1);
        halt_req = 1'b0;
        do_stage(1, 1);
        do_stage(2, ed);
        if (mem) begin
            wait_go(3);
            mcyc = 0;
            mgo  = 0;
            for (int i = 0; i < md; i++) begin
                if (m_state == 3'd4) mcyc++;
                if (m_mem_go) mgo++;
                step();
            end
            if (m_state == 3'd4) mcyc++;
            if (m_mem_go) mgo++;
            mem_ready = 1'b1;
            step();
            mem_ready = 1'b0;
            check("mem_cycles", 32'(mcyc), 32'(md + 1));
            check("mem_go_pulses", 32'(mgo), 32'd1);
        end
        check("wb_state", {29'd0, m_state}, 32'd5);
        check("wb_go", {31'd0, m_wb_go}, 32'd1);
        check("pc_in_wb", m_pc, exp_pc);
        if (do_halt) halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("pc_after_wb", m_pc, exp_next);
        check("count_after_wb", m_count, exp_cnt);
        check("state_after_wb", {29'd0, m_state}, do_halt ? 32'd6 : 32'd1);
        check("busy_after_wb", {31'd0, m_busy}, do_halt ? 32'd0 : 32'd1);
    endtask

    initial begin
        sel = 1'b0; start = 1'b0; halt_req = 1'b0;
        fetch_done = 1'b0; decode_done = 1'b0; exec_done = 1'b0; mem_ready = 1'b0;
        mem_needed = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        do_reset();
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_count", instr_count, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, timeout_err}, 32'd0);
        check("rst_fetch_go", {31'd0, fetch_go}, 32'd0);

        // halt_req is ignored in IDLE; fetch_go follows the cycle after start
        start = 1'b1; halt_req = 1'b1;
        step();
        start = 1'b0; halt_req = 1'b0;
        check("idle_exit_state", {29'd0, state}, 32'd1);
        check("idle_exit_go", {31'd0, fetch_go}, 32'd1);

        run_instr(32'h0,   32'h4,   32'd1, 1'b0, 0,  1'b0, 32'h0,   1, 1'b0, 1'b0, 0);
        run_instr(32'h4,   32'h8,   32'd2, 1'b0, 0,  1'b0, 32'h0,   1, 1'b0, 1'b0, 7);
        run_instr(32'h8,   32'hC,   32'd3, 1'b0, 0,  1'b0, 32'h0,   1, 1'b0, 1'b0, 7);
        run_instr(32'hC,   32'h100, 32'd4, 1'b0, 0,  1'b1, 32'h100, 1, 1'b0, 1'b0, 7);
        run_instr(32'h100, 32'h104, 32'd5, 1'b0, 0,  1'b0, 32'h200, 1, 1'b0, 1'b1, 7);
        run_instr(32'h104, 32'h108, 32'd6, 1'b1, 10, 1'b0, 32'h0,   1, 1'b0, 1'b0, 7);
        run_instr(32'h108, 32'h10C, 32'd7, 1'b0, 0,  1'b0, 32'h0,   1, 1'b1, 1'b0, 18);

        start = 1'b1; halt_req = 1'b1;
        step();
        check("halt_hold_state", {29'd0, state}, 32'd6);
        halt_req = 1'b0;
        step();
        start = 1'b0;
        check("resume_state", {29'd0, state}, 32'd1);
        check("resume_go", {31'd0, fetch_go}, 32'd1);
        check("resume_pc", pc, 32'h10C);

        // async reset in the middle of MEM
        mem_needed = 1'b1;
        do_stage(0, 1);
        do_stage(1, 1);
        do_stage(2, 1);
        wait_go(3);
        step(); step(); step();
        check("pre_rst_state", {29'd0, state}, 32'd4);
        rst = 1'b1;
        #1;
        check("arst_state", {29'd0, state}, 32'd0);
        check("arst_pc", pc, 32'd0);
        check("arst_count", instr_count, 32'd0);
        check("arst_gos", {27'd0, fetch_go, decode_go, exec_go, mem_go, wb_go}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        step();
        rst = 1'b0;
        mem_needed = 1'b0;

        // TIMEOUT=4 instance: exec_done withheld
        sel = 1'b1;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        do_stage(0, 1);
        do_stage(1, 1);
        wait_go(2);
        repeat (4) step();
        check("to_still_exec", {29'd0, t_state}, 32'd3);
        check("to_no_err_yet", {31'd0, t_timeout_err}, 32'd0);
        step();
        check("to_state_halt", {29'd0, t_state}, 32'd6);
        check("to_err", {31'd0, t_timeout_err}, 32'd1);
        check("to_pc", t_pc, 32'd0);
        check("to_count", t_instr_count, 32'd0);
        check("to_busy", {31'd0, t_busy}, 32'd0);
        repeat (3) step();
        check("to_err_sticky", {31'd0, t_timeout_err}, 32'd1);

        // done exactly at go+4 is still accepted
        do_reset();
        check("to_err_cleared", {31'd0, t_timeout_err}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        run_instr(32'h0, 32'h4, 32'd1, 1'b0, 0, 1'b0, 32'h0, 4, 1'b0, 1'b0, 0);
        check("edge_no_err", {31'd0, t_timeout_err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle controller for the non-pipelined MIPS core: it sequences the fetch, decode, execute, memory and writeback stages one instruction at a time over the per-stage go/done handshake. It owns the architectural PC and resolves branches from the execute stage's zero flag and branch target. It retires instructions in order, counts them, and detects a stage that never answers.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- TIMEOUT, 255, max cycles after a go pulse to wait for the matching done (1..255)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  level; leave IDLE/HALT and begin fetching
- halt_req  in  1  level; stop after the current instruction retires
- fetch_go  out  1  one-cycle request to the fetch stage
- fetch_done  in  1  fetch complete
- decode_go  out  1  one-cycle request to decode
- decode_done  in  1  decode complete
- mem_needed  in  1  sampled with decode_done; 1 = instruction uses the MEM stage
- exec_go  out  1  one-cycle request to execute (drives its done_in)
- exec_done  in  1  execute complete (its done_out)
- branch_taken  in  1  execute zero flag, sampled with exec_done
- branch_target  in  32  execute PC_out, sampled with exec_done
- mem_go  out  1  one-cycle request to data memory
- mem_ready  in  1  memory access complete, variable latency
- wb_go  out  1  one-cycle writeback strobe
- pc  out  32  PC of the instruction in flight
- busy  out  1  1 in FETCH/DECODE/EXEC/MEM/WB
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6
- instr_count  out  32  retired instructions, wraps at 2^32
- timeout_err  out  1  sticky; a stage missed its done window

## Operation
- Reset (async): state=IDLE, all *_go=0, pc=RESET_PC, next_pc=RESET_PC, busy=0, instr_count=0, timeout_err=0, wait counter=0.
- IDLE: start=1 -> FETCH. halt_req is ignored in IDLE.
- Each wait state (FETCH, DECODE, EXEC, MEM) asserts its go for exactly the first cycle in that state. Its done is sampled only on later cycles; a done in the go cycle is ignored. Done may stay high; only the first sampled assertion counts.
- FETCH done -> DECODE.
- DECODE done -> EXEC. The mem_needed flag is latched.
- EXEC done: next_pc <= branch_taken ? branch_target : pc+4 (32-bit wrap). Then -> MEM if mem_needed was latched, else -> WB.
- MEM done (mem_ready) -> WB.
- WB (one cycle): wb_go=1, pc <= next_pc, instr_count += 1. Then -> HALT if halt_req=1 in that cycle, else -> FETCH.
- HALT: busy=0, pc holds. start=1 with halt_req=0 -> FETCH at the current pc. start=1 with halt_req=1 stays in HALT.
- Timeout: a wait counter clears on entry to each wait state and increments every cycle there.
  - Done is accepted up to and including cycle go+TIMEOUT.
  - If none arrives by then: timeout_err <= 1, -> HALT. pc and instr_count are not updated.
  - timeout_err clears only on rst.
- halt_req only matters in WB. An asserted then deasserted request that misses WB has no effect.
- Async rst in any state aborts the instruction at once and returns all outputs to their reset values.

## Timing
- State registered; *_go and busy are decoded from state and the first-cycle flag, glitch-free.
- Minimum instruction time with done arriving one cycle after go:
  - FETCH 2 + DECODE 2 + EXEC 2 + WB 1 = 7 cycles without memory.
  - 9 cycles with MEM.
- IDLE/HALT exit: the cycle after start is sampled is the fetch_go cycle.
- pc changes only on the edge ending WB, so it is stable for all go pulses of one instruction.
- instr_count wraps 32'hFFFF_FFFF -> 0 silently.

## Test plan
- Reset, start=1, every done returned one cycle after go, mem_needed=0, branch_taken=0 -> fetch_go every 7 cycles; pc 0,4,8; instr_count 3 after three WBs.
- branch_taken=1, branch_target=32'h0000_0100 at exec_done -> next fetch_go with pc=32'h100. The same with branch_taken=0 -> pc+4.
- mem_needed=1, mem_ready delayed 10 cycles -> MEM lasts 11 cycles, exactly one mem_go pulse, then WB.
- TIMEOUT=4, exec_done withheld -> timeout_err=1 and state=HALT at cycle exec_go+5; done at go+4 in a separate run is accepted with no error.
- halt_req=1 during WB -> state=HALT, busy=0. start with halt_req=1 stays HALT; start alone resumes at the held pc.
- Assert rst mid-MEM -> state=IDLE, pc=RESET_PC, instr_count=0, all go=0 immediately.
